// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array slice: default geometry,
// buffer address widths and the tile sequencer state encoding.
package systolic_pkg;

    localparam int DEFAULT_ARRAY_M         = 4;
    localparam int DEFAULT_ARRAY_N         = 4;
    localparam int DEFAULT_PIPE_LATENCY    = DEFAULT_ARRAY_N + 1;
    localparam int DEFAULT_LOOP_WIDTH      = 16;
    localparam int DEFAULT_IBUF_ADDR_WIDTH = 16;
    localparam int DEFAULT_WBUF_ADDR_WIDTH = 16;
    localparam int DEFAULT_OBUF_ADDR_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WLOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } tile_state_t;

endpackage

// File: rtl/systolic_tile_ctrl_delay_line.sv
// Fixed-depth shift register that carries {valid, addr} words; the MSB of each
// word is treated as its valid bit so the owner can tell when writes are in flight.
module systolic_tile_ctrl_delay_line #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             inflight
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

    // The head is excluded: it is being written out this cycle and will be gone next.
    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            inflight = inflight | stages[i][WIDTH-1];
        end
    end

endmodule

// File: rtl/systolic_tile_ctrl.sv
// GEMM tile sequencer: per weight block, one weight-buffer read followed by R
// input-buffer reads, with output-buffer writes delayed to match array latency.
module systolic_tile_ctrl
    import systolic_pkg::*;
#(
    parameter int ARRAY_M         = DEFAULT_ARRAY_M,
    parameter int ARRAY_N         = DEFAULT_ARRAY_N,
    parameter int PIPE_LATENCY    = ARRAY_N + 1,
    parameter int LOOP_WIDTH      = DEFAULT_LOOP_WIDTH,
    parameter int IBUF_ADDR_WIDTH = DEFAULT_IBUF_ADDR_WIDTH,
    parameter int WBUF_ADDR_WIDTH = DEFAULT_WBUF_ADDR_WIDTH,
    parameter int OBUF_ADDR_WIDTH = DEFAULT_OBUF_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [LOOP_WIDTH-1:0]      cfg_rows,
    input  logic [LOOP_WIDTH-1:0]      cfg_kblocks,
    input  logic [IBUF_ADDR_WIDTH-1:0] cfg_ibuf_base,
    input  logic [WBUF_ADDR_WIDTH-1:0] cfg_wbuf_base,
    input  logic [OBUF_ADDR_WIDTH-1:0] cfg_obuf_base,
    output logic                       busy,
    output logic                       done,
    output logic                       acc_clear,
    output logic                       wbuf_read_req,
    output logic [WBUF_ADDR_WIDTH-1:0] wbuf_read_addr,
    output logic                       ibuf_read_req,
    output logic [IBUF_ADDR_WIDTH-1:0] ibuf_read_addr,
    output logic                       obuf_write_req,
    output logic [OBUF_ADDR_WIDTH-1:0] obuf_write_addr
);

    localparam int PROD_WIDTH = 2 * LOOP_WIDTH;
    localparam logic [LOOP_WIDTH-1:0] LOOP_ONE = LOOP_WIDTH'(1);

    if (ARRAY_M < 1 || ARRAY_N < 1 || PIPE_LATENCY < 1) begin : g_bad_geometry
        $error("systolic_tile_ctrl: array dimensions and PIPE_LATENCY must be >= 1");
    end

    tile_state_t state, state_next;

    logic [LOOP_WIDTH-1:0]      rows_q, kblocks_q;
    logic [LOOP_WIDTH-1:0]      k_cnt, r_cnt;
    logic [IBUF_ADDR_WIDTH-1:0] ibuf_base_q, ibuf_hold;
    logic [WBUF_ADDR_WIDTH-1:0] wbuf_base_q, wbuf_hold;
    logic [OBUF_ADDR_WIDTH-1:0] obuf_base_q, obuf_hold;

    logic                       accept, zero_cmd, last_row, last_block, inflight;
    logic [PROD_WIDTH-1:0]      kr_product;
    logic [IBUF_ADDR_WIDTH-1:0] ibuf_live;
    logic [WBUF_ADDR_WIDTH-1:0] wbuf_live;
    logic [OBUF_ADDR_WIDTH-1:0] obuf_live;
    logic [OBUF_ADDR_WIDTH:0]   pipe_in, pipe_out;

    assign accept     = (state == ST_IDLE) && start;
    assign zero_cmd   = (cfg_rows == '0) || (cfg_kblocks == '0);
    assign last_row   = (r_cnt == rows_q - LOOP_ONE);
    assign last_block = (k_cnt == kblocks_q - LOOP_ONE);

    assign kr_product = PROD_WIDTH'(k_cnt) * PROD_WIDTH'(rows_q);
    assign ibuf_live  = ibuf_base_q + IBUF_ADDR_WIDTH'(kr_product) + IBUF_ADDR_WIDTH'(r_cnt);
    assign wbuf_live  = wbuf_base_q + WBUF_ADDR_WIDTH'(k_cnt);
    assign obuf_live  = obuf_base_q + OBUF_ADDR_WIDTH'(r_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        busy           = (state != ST_IDLE);
        done           = 1'b0;
        acc_clear      = 1'b0;
        wbuf_read_req  = 1'b0;
        ibuf_read_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                acc_clear = start;
                if (start) begin
                    state_next = zero_cmd ? ST_DONE : ST_WLOAD;
                end
            end
            ST_WLOAD: begin
                wbuf_read_req = 1'b1;
                state_next    = ST_STREAM;
            end
            ST_STREAM: begin
                ibuf_read_req = 1'b1;
                if (last_row) begin
                    state_next = last_block ? ST_DRAIN : ST_WLOAD;
                end
            end
            ST_DRAIN: begin
                if (!inflight) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command latch plus row/block loop counters; the config is frozen at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_q      <= '0;
            kblocks_q   <= '0;
            ibuf_base_q <= '0;
            wbuf_base_q <= '0;
            obuf_base_q <= '0;
            k_cnt       <= '0;
            r_cnt       <= '0;
        end else if (accept) begin
            rows_q      <= cfg_rows;
            kblocks_q   <= cfg_kblocks;
            ibuf_base_q <= cfg_ibuf_base;
            wbuf_base_q <= cfg_wbuf_base;
            obuf_base_q <= cfg_obuf_base;
            k_cnt       <= '0;
            r_cnt       <= '0;
        end else if (state == ST_STREAM) begin
            if (last_row) begin
                r_cnt <= '0;
                k_cnt <= k_cnt + LOOP_ONE;
            end else begin
                r_cnt <= r_cnt + LOOP_ONE;
            end
        end
    end

    assign pipe_in = {ibuf_read_req, obuf_live};

    systolic_tile_ctrl_delay_line #(
        .DEPTH (PIPE_LATENCY),
        .WIDTH (OBUF_ADDR_WIDTH + 1)
    ) u_delay_line (
        .clk      (clk),
        .reset    (reset),
        .din      (pipe_in),
        .dout     (pipe_out),
        .inflight (inflight)
    );

    // Address ports keep showing the last issued address while their request is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbuf_hold <= '0;
            ibuf_hold <= '0;
            obuf_hold <= '0;
        end else begin
            if (wbuf_read_req) wbuf_hold <= wbuf_live;
            if (ibuf_read_req) ibuf_hold <= ibuf_live;
            if (obuf_write_req) obuf_hold <= pipe_out[OBUF_ADDR_WIDTH-1:0];
        end
    end

    assign obuf_write_req  = pipe_out[OBUF_ADDR_WIDTH];
    assign wbuf_read_addr  = wbuf_read_req  ? wbuf_live : wbuf_hold;
    assign ibuf_read_addr  = ibuf_read_req  ? ibuf_live : ibuf_hold;
    assign obuf_write_addr = obuf_write_req ? pipe_out[OBUF_ADDR_WIDTH-1:0] : obuf_hold;

endmodule
